// File: rtl/game_controller.sv
// Game-flow controller for the binary-number guessing game: sequences welcome,
// round start, timed guessing, loss and win, and owns level, lives and round timer.
module game_controller #(
   parameter int LEVEL_W    = 8,
   parameter int TIME_W     = 5,
   parameter int LIVES_W    = 2,
   parameter int TIME_START = 30,
   parameter int TIME_STEP  = 2,
   parameter int TIME_MIN   = 3,
   parameter int MAX_LEVEL  = 16,
   parameter int LIVES      = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               guess_b,
   input  logic               cmp_r,
   output logic [2:0]         state,
   output logic [LEVEL_W-1:0] level,
   output logic [LIVES_W-1:0] lives,
   output logic [TIME_W-1:0]  time_v,
   output logic               time_f,
   output logic               time_out,
   output logic               g_enable
);

   localparam int CW = LEVEL_W + TIME_W + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_PLAY  = 3'd2,
      S_LOSE  = 3'd3,
      S_WIN   = 3'd4
   } state_t;

   state_t             state_reg;
   logic [LEVEL_W-1:0] level_reg;
   logic [LIVES_W-1:0] lives_reg;
   logic [TIME_W-1:0]  time_v_reg;
   logic               time_f_reg;
   logic               time_out_reg;
   logic               g_enable_reg;
   logic               guess_q;

   logic               press;
   logic [LEVEL_W-1:0] level_inc;
   logic [LIVES_W-1:0] lives_dec;
   logic [TIME_W-1:0]  time_load;
   logic [CW-1:0]      level_ext;
   logic signed [CW-1:0] t_calc;
   logic signed [CW-1:0] t_sel;

   assign press     = guess_b & ~guess_q;
   assign level_inc = (level_reg == LEVEL_W'(MAX_LEVEL)) ? level_reg : level_reg + 1'b1;
   assign lives_dec = (lives_reg != '0) ? lives_reg - 1'b1 : '0;
   assign level_ext = {{(CW-LEVEL_W){1'b0}}, level_reg};

   // Round time shrinks with level; the extra headroom bit lets a negative
   // result show up as negative so it clamps to the floor instead of wrapping.
   always_comb begin
      t_calc = $signed(CW'(TIME_START) - CW'(TIME_STEP) * level_ext);
      t_sel  = t_calc;
      if (t_calc < $signed(CW'(TIME_MIN)))
         t_sel = $signed(CW'(TIME_MIN));
   end
   assign time_load = TIME_W'(t_sel);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         level_reg    <= '0;
         lives_reg    <= LIVES_W'(LIVES);
         time_v_reg   <= TIME_W'(TIME_START);
         time_f_reg   <= 1'b0;
         time_out_reg <= 1'b0;
         g_enable_reg <= 1'b1;
         guess_q      <= 1'b0;
      end else begin
         guess_q      <= guess_b;
         time_out_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (press)
                  state_reg <= S_READY;
            end
            S_READY: begin
               if (press) begin
                  state_reg    <= S_PLAY;
                  time_v_reg   <= time_load;
                  time_f_reg   <= 1'b1;
                  g_enable_reg <= 1'b0;
               end
            end
            S_PLAY: begin
               // A press takes priority and swallows a coincident tick.
               if (press) begin
                  time_f_reg   <= 1'b0;
                  g_enable_reg <= 1'b1;
                  if (cmp_r) begin
                     level_reg <= level_inc;
                     state_reg <= (level_inc == LEVEL_W'(MAX_LEVEL)) ? S_WIN : S_READY;
                  end else begin
                     lives_reg <= lives_dec;
                     state_reg <= (lives_dec == '0) ? S_LOSE : S_READY;
                  end
               end else if (tick) begin
                  if (time_v_reg <= TIME_W'(1)) begin
                     time_v_reg   <= '0;
                     time_out_reg <= 1'b1;
                     time_f_reg   <= 1'b0;
                     g_enable_reg <= 1'b1;
                     lives_reg    <= lives_dec;
                     state_reg    <= (lives_dec == '0) ? S_LOSE : S_READY;
                  end else begin
                     time_v_reg <= time_v_reg - 1'b1;
                  end
               end
            end
            S_LOSE, S_WIN: begin
               if (press) begin
                  state_reg <= S_READY;
                  level_reg <= '0;
                  lives_reg <= LIVES_W'(LIVES);
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign state    = state_reg;
   assign level    = level_reg;
   assign lives    = lives_reg;
   assign time_v   = time_v_reg;
   assign time_f   = time_f_reg;
   assign time_out = time_out_reg;
   assign g_enable = g_enable_reg;

endmodule
